// File: rtl/dro_pulse_sequencer_if.sv
// dro_pulse_sequencer_if: host request/ack, readout and DRO pin bundle for the pulse sequencer
interface dro_pulse_sequencer_if;
   logic wr_req, wr_ack, rd_req, rd_ack, rd_valid, rd_data;
   logic dro_set, dro_reset, dro_out, busy;
   logic err_dbl_set, err_mismatch, err_spurious;
   modport master (
      output wr_req, rd_req, dro_out,
      input  wr_ack, rd_ack, rd_valid, rd_data, dro_set, dro_reset, busy,
             err_dbl_set, err_mismatch, err_spurious
   );
   modport slave (
      input  wr_req, rd_req, dro_out,
      output wr_ack, rd_ack, rd_valid, rd_data, dro_set, dro_reset, busy,
             err_dbl_set, err_mismatch, err_spurious
   );
endinterface

// File: rtl/dro_pulse_sequencer.sv
// dro_pulse_sequencer: arbitrates set/readout pulses to one DRO cell, captures its output, flags errors
module dro_pulse_sequencer #(
   parameter int PULSE_W = 2,
   parameter int SEP_CYC = 3,
   parameter int OUT_WIN = 4,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   dro_pulse_sequencer_if.slave   io
);
   typedef enum logic [2:0] {IDLE, SETP, RSTP, CAPT, GAP} state_t;
   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              stored, stored_n, last_wr, last_wr_n, cap, cap_n, cap_mux;
   logic              window, grant_rd, grant_wr, rd_done, pulse_end;
   logic              rd_data_n, dbl_n, mism_n, spur_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         stored          <= 1'b0;
         last_wr         <= 1'b1;
         cap             <= 1'b0;
         io.wr_ack       <= 1'b0;
         io.rd_ack       <= 1'b0;
         io.rd_valid     <= 1'b0;
         io.rd_data      <= 1'b0;
         io.dro_set      <= 1'b0;
         io.dro_reset    <= 1'b0;
         io.busy         <= 1'b0;
         io.err_dbl_set  <= 1'b0;
         io.err_mismatch <= 1'b0;
         io.err_spurious <= 1'b0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         stored          <= stored_n;
         last_wr         <= last_wr_n;
         cap             <= cap_n;
         io.wr_ack       <= grant_wr;
         io.rd_ack       <= grant_rd;
         io.rd_valid     <= rd_done;
         io.rd_data      <= rd_data_n;
         io.dro_set      <= state_n == SETP;
         io.dro_reset    <= state_n == RSTP;
         io.busy         <= state_n != IDLE;
         io.err_dbl_set  <= dbl_n;
         io.err_mismatch <= mism_n;
         io.err_spurious <= spur_n;
      end
   end
   always_comb begin
      window    = state == RSTP || state == CAPT;
      grant_rd  = state == IDLE && io.rd_req && (!io.wr_req || last_wr);
      grant_wr  = state == IDLE && io.wr_req && !grant_rd;
      pulse_end = cnt == CNT_W'(PULSE_W - 1);
      rd_done   = (state == RSTP && pulse_end && OUT_WIN == 0) ||
                  (state == CAPT && cnt == CNT_W'(OUT_WIN - 1));
      state_n   = state;
      case (state)
         IDLE:    state_n = grant_wr ? SETP : grant_rd ? RSTP : IDLE;
         SETP:    state_n = pulse_end ? GAP : SETP;
         RSTP:    state_n = pulse_end ? (OUT_WIN == 0 ? GAP : CAPT) : RSTP;
         CAPT:    state_n = rd_done ? GAP : CAPT;
         GAP:     state_n = cnt == CNT_W'(SEP_CYC - 1) ? IDLE : GAP;
         default: state_n = IDLE;
      endcase
      cnt_n     = (state_n != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
      cap_mux   = cap | io.dro_out;
      cap_n     = grant_rd ? 1'b0 : window ? cap_mux : cap;
      stored_n  = grant_wr ? 1'b1 : rd_done ? 1'b0 : stored;
      last_wr_n = grant_wr ? 1'b1 : grant_rd ? 1'b0 : last_wr;
      rd_data_n = rd_done ? cap_mux : io.rd_data;
      dbl_n     = io.err_dbl_set | (grant_wr & stored);
      mism_n    = io.err_mismatch | (rd_done & (cap_mux != stored));
      spur_n    = io.err_spurious | (io.dro_out & !window);
   end
endmodule

// File: tb/tb_dro_pulse_sequencer.sv
// tb_dro_pulse_sequencer: directed scenarios for the DRO pulse sequencer
module tb_dro_pulse_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   fails = 0;
   always #5 clk = ~clk;
   dro_pulse_sequencer_if bus();
   dro_pulse_sequencer dut (.clk(clk), .rst(rst), .io(bus.slave));
   // {wr_ack, rd_ack, rd_valid, rd_data, dro_set, dro_reset, busy}
   function automatic logic [6:0] obs();
      return {bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.rd_data, bus.dro_set, bus.dro_reset, bus.busy};
   endfunction
   function automatic logic [2:0] errs();
      return {bus.err_dbl_set, bus.err_mismatch, bus.err_spurious};
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      bus.dro_out = 1'b0;
      step();
      step();
   endtask
   task automatic test_reset();
      do_reset();
      checks++;
      if (obs() !== 7'b0) begin fails++; $display("FAIL reset_outputs: got %b want %b", obs(), 7'b0); end
      checks++;
      if (errs() !== 3'b0) begin fails++; $display("FAIL reset_errors: got %b want %b", errs(), 3'b0); end
   endtask
   task automatic test_write();
      logic [6:0] e [6] = '{7'b1000101, 7'b0000101, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000000};
      rst = 1'b0;
      bus.wr_req = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i == 1) bus.wr_req = 1'b0;
         checks++;
         if (obs() !== e[i-1]) begin fails++; $display("FAIL write_c%0d: got %b want %b", i, obs(), e[i-1]); end
      end
      checks++;
      if (errs() !== 3'b0) begin fails++; $display("FAIL write_errors: got %b want %b", errs(), 3'b0); end
   endtask
   task automatic test_read();
      logic [6:0] e [10] = '{7'b0100011, 7'b0000011, 7'b0000001, 7'b0000001, 7'b0000001,
                             7'b0000001, 7'b0011001, 7'b0001001, 7'b0001001, 7'b0001000};
      for (int i = 0; i < 4; i++) step();
      bus.rd_req = 1'b1;
      for (int i = 11; i <= 20; i++) begin
         step();
         if (i == 11) bus.rd_req = 1'b0;
         bus.dro_out = (i == 12);
         checks++;
         if (obs() !== e[i-11]) begin fails++; $display("FAIL read_c%0d: got %b want %b", i, obs(), e[i-11]); end
      end
      checks++;
      if (errs() !== 3'b0) begin fails++; $display("FAIL read_errors: got %b want %b", errs(), 3'b0); end
   endtask
   task automatic test_arbitration();
      logic [6:0] e [13] = '{7'b0100011, 7'b0000011, 7'b0000001, 7'b0000001, 7'b0000001,
                             7'b0000001, 7'b0010001, 7'b0000001, 7'b0000001, 7'b0000000,
                             7'b1000101, 7'b0000101, 7'b0000001};
      do_reset();
      rst = 1'b0;
      bus.wr_req = 1'b1;
      bus.rd_req = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         step();
         if (i == 1) bus.rd_req = 1'b0;
         if (i == 11) bus.wr_req = 1'b0;
         checks++;
         if (obs() !== e[i-1]) begin fails++; $display("FAIL arb_c%0d: got %b want %b", i, obs(), e[i-1]); end
      end
      checks++;
      if (errs() !== 3'b0) begin fails++; $display("FAIL arb_errors: got %b want %b", errs(), 3'b0); end
   endtask
   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (obs() !== 7'b0) begin fails++; $display("FAIL b2b_idle: got %b want %b", obs(), 7'b0); end
      bus.wr_req = 1'b1;
      step();
      bus.wr_req = 1'b0;
      checks++;
      if (obs() !== 7'b1000101) begin fails++; $display("FAIL b2b_set1: got %b want %b", obs(), 7'b1000101); end
      checks++;
      if (errs() !== 3'b100) begin fails++; $display("FAIL b2b_dbl: got %b want %b", errs(), 3'b100); end
      step();
      checks++;
      if (obs() !== 7'b0000101) begin fails++; $display("FAIL b2b_set2: got %b want %b", obs(), 7'b0000101); end
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (obs() !== 7'b0) begin fails++; $display("FAIL b2b_end: got %b want %b", obs(), 7'b0); end
      checks++;
      if (errs() !== 3'b100) begin fails++; $display("FAIL b2b_sticky: got %b want %b", errs(), 3'b100); end
   endtask
   task automatic test_spurious_mismatch();
      do_reset();
      rst = 1'b0;
      bus.wr_req = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         step();
         if (i == 1) bus.wr_req = 1'b0;
         bus.dro_out = (i == 3);
         if (i == 6) bus.rd_req = 1'b1;
         if (i == 7) bus.rd_req = 1'b0;
         if (i == 3) begin
            checks++;
            if (errs() !== 3'b000) begin fails++; $display("FAIL spur_before: got %b want %b", errs(), 3'b000); end
         end
         if (i == 4 || i == 12) begin
            checks++;
            if (errs() !== 3'b001) begin fails++; $display("FAIL spur_c%0d: got %b want %b", i, errs(), 3'b001); end
         end
         if (i == 13) begin
            checks++;
            if (obs() !== 7'b0010001) begin fails++; $display("FAIL mism_valid: got %b want %b", obs(), 7'b0010001); end
            checks++;
            if (errs() !== 3'b011) begin fails++; $display("FAIL mism_flag: got %b want %b", errs(), 3'b011); end
         end
      end
   endtask
   task automatic test_reset_mid();
      do_reset();
      rst = 1'b0;
      bus.wr_req = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i == 1) bus.wr_req = 1'b0;
      end
      bus.rd_req = 1'b1;
      step();
      bus.rd_req = 1'b0;
      checks++;
      if (obs() !== 7'b0100011) begin fails++; $display("FAIL rstmid_ack: got %b want %b", obs(), 7'b0100011); end
      step();
      checks++;
      if (obs() !== 7'b0000011) begin fails++; $display("FAIL rstmid_pulse: got %b want %b", obs(), 7'b0000011); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (obs() !== 7'b0) begin fails++; $display("FAIL rstmid_cut: got %b want %b", obs(), 7'b0); end
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (obs() !== 7'b0) begin fails++; $display("FAIL rstmid_quiet%0d: got %b want %b", i, obs(), 7'b0); end
      end
      bus.wr_req = 1'b1;
      step();
      bus.wr_req = 1'b0;
      checks++;
      if (obs() !== 7'b1000101) begin fails++; $display("FAIL rstmid_wr: got %b want %b", obs(), 7'b1000101); end
      checks++;
      if (errs() !== 3'b000) begin fails++; $display("FAIL rstmid_stored: got %b want %b", errs(), 3'b000); end
   endtask
   initial begin
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      bus.dro_out = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_arbitration();
      test_back_to_back();
      test_spurious_mismatch();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
